// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign/shifted-sign/upper-place extension
// of an IN_W-bit field to OUT_W bits behind a two-entry (output + skid) buffer.
module imm_extend_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    localparam int PAD_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;

    logic             accept;
    logic             consume;

    logic             o_valid_q, o_valid_d;
    logic [OUT_W-1:0] o_data_q,  o_data_d;
    logic             s_valid_q, s_valid_d;
    logic [OUT_W-1:0] s_data_q,  s_data_d;

    // Size casts handle IN_W == OUT_W without a zero-width replication.
    always_comb begin
        zext     = OUT_W'(in_imm);
        sext     = OUT_W'($signed(in_imm));
        ext_data = zext;
        case (in_mode)
            MODE_ZERO:  ext_data = zext;
            MODE_SIGN:  ext_data = sext;
            MODE_SHIFT: ext_data = sext << 1;
            MODE_UPPER: ext_data = zext << PAD_W;
            default:    ext_data = zext;
        endcase
    end

    // Handshake: a transfer happens on a side only when valid and ready are
    // both high at the rising edge; a producer holding valid must keep its
    // data stable until ready is seen.
    assign accept  = in_valid && !s_valid_q;
    assign consume = o_valid_q && out_ready;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (!o_valid_q || (consume && !s_valid_q)) begin
            o_valid_d = accept;
            if (accept) begin
                o_data_d = ext_data;
            end
        end else if (consume) begin
            // Skid entry is older than anything arriving now.
            o_valid_d = 1'b1;
            o_data_d  = s_data_q;
            s_valid_d = accept;
            if (accept) begin
                s_data_d = ext_data;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = ext_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

    assign in_ready  = !s_valid_q;
    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;
    assign out_neg   = o_data_q[OUT_W-1];

endmodule
